// File: rtl/mandel_result_collector_pkg.sv
// Shared constants for the Mandelbrot load balancer, used on both the dispatch and return sides.
// The one-hot/binary helper is shared so both directions of the lane index agree.
package mandel_result_collector_pkg;

    localparam int N_SOLVERS   = 4;
    localparam int ADDR_W      = 19;
    localparam int ITER_W      = 10;
    localparam int PIXELS      = 307200;
    localparam int SRC_W       = $clog2(N_SOLVERS);

    // Widest supported lane count; narrower users zero-extend into the helper.
    localparam int MAX_SOLVERS = 16;
    localparam int MAX_SRC_W   = $clog2(MAX_SOLVERS);

    function automatic logic [MAX_SRC_W-1:0] onehot_to_bin(input logic [MAX_SOLVERS-1:0] oh);
        logic [MAX_SRC_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_SOLVERS; i++) begin
            if (oh[i]) begin
                bin = bin | MAX_SRC_W'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/mandel_result_collector_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins, with wrap-around.
// The grant is gated by the enable; the binary index is always of the raw winner.
module rr_arbiter
    import mandel_result_collector_pkg::*;
#(
    parameter int N     = N_SOLVERS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]     pick;
    logic [IDX_W-1:0] lane;
    logic             found;

    // N is a power of two, so the IDX_W-bit sum wraps exactly at N.
    always_comb begin
        pick  = '0;
        lane  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane = ptr_i + IDX_W'(i);
            if (!found && req_i[lane]) begin
                pick[lane] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt_o = pick & {N{en_i}};
    assign idx_o = IDX_W'(onehot_to_bin(MAX_SOLVERS'(pick)));

endmodule

// File: rtl/mandel_result_collector.sv
// Return path of the Mandelbrot load balancer: arbitrates solver results into a single
// registered valid/ready stream for the pixel writer and counts pixels per frame.
module mandel_result_collector #(
    parameter int N_SOLVERS = mandel_result_collector_pkg::N_SOLVERS,
    parameter int ADDR_W    = mandel_result_collector_pkg::ADDR_W,
    parameter int ITER_W    = mandel_result_collector_pkg::ITER_W,
    parameter int PIXELS    = mandel_result_collector_pkg::PIXELS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic [N_SOLVERS-1:0]            done_req,
    input  logic [N_SOLVERS*ADDR_W-1:0]     done_addr,
    input  logic [N_SOLVERS*ITER_W-1:0]     done_iter,
    output logic [N_SOLVERS-1:0]            done_ack,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDR_W-1:0]               out_addr,
    output logic [ITER_W-1:0]               out_iter,
    output logic [$clog2(N_SOLVERS)-1:0]    out_src,
    output logic [$clog2(PIXELS+1)-1:0]     pix_count,
    output logic                            frame_done
);

    localparam int SRC_W = $clog2(N_SOLVERS);
    localparam int CNT_W = $clog2(PIXELS + 1);
    localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(PIXELS);

    logic                 load;
    logic                 xfer;
    logic [N_SOLVERS-1:0] gnt;
    logic [SRC_W-1:0]     win;

    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [ITER_W-1:0]    iter_q,  iter_d;
    logic [SRC_W-1:0]     src_q,   src_d;
    logic [SRC_W-1:0]     ptr_q,   ptr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 fdone_q, fdone_d;

    assign load = (|done_req) && (!valid_q || out_ready);
    assign xfer = valid_q && out_ready;

    // Reset gates the enable so no solver sees an ack it would act on while we are held.
    rr_arbiter #(
        .N     (N_SOLVERS),
        .IDX_W (SRC_W)
    ) u_arb (
        .req_i (done_req),
        .ptr_i (ptr_q),
        .en_i  (load && reset),
        .gnt_o (gnt),
        .idx_o (win)
    );

    assign done_ack = gnt;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        iter_d  = iter_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = done_addr[int'(win)*ADDR_W +: ADDR_W];
            iter_d  = done_iter[int'(win)*ITER_W +: ITER_W];
            src_d   = win;
            ptr_d   = win + SRC_W'(1);
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // A transfer coincident with frame_start belongs to the new frame.
    always_comb begin
        cnt_d   = cnt_q;
        fdone_d = fdone_q;
        if (frame_start) begin
            cnt_d   = xfer ? CNT_W'(1) : '0;
            fdone_d = xfer && (PIXELS == 1);
        end else if (xfer && (cnt_q != PIX_MAX)) begin
            cnt_d   = cnt_q + CNT_W'(1);
            fdone_d = (cnt_d == PIX_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            iter_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            fdone_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            iter_q  <= iter_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fdone_q <= fdone_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_addr   = addr_q;
    assign out_iter   = iter_q;
    assign out_src    = src_q;
    assign pix_count  = cnt_q;
    assign frame_done = fdone_q;

endmodule
